// File: rtl/muldiv_unit_pkg.sv
// ============================================================================
// Module  : muldiv_unit_pkg
// Brief   : Operation codes, FSM state encoding and decode helpers for the
//           iterative multiply/divide unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_unit_pkg;

  localparam logic [1:0] MDOP_MULT  = 2'd0;
  localparam logic [1:0] MDOP_MULTU = 2'd1;
  localparam logic [1:0] MDOP_DIV   = 2'd2;
  localparam logic [1:0] MDOP_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MDOP_MULT) || (op == MDOP_DIV);
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == MDOP_DIV) || (op == MDOP_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/md_sign_fix.sv
// ============================================================================
// Module  : md_sign_fix
// Brief   : Combinational two's-complement negate-if-flag of a W-bit value.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module md_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? (W'(0) - val) : val;

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module  : muldiv_unit
// Brief   : Iterative 32-cycle shift-add multiplier / restoring divider that
//           owns the architectural HI/LO registers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Start,
  input  logic [1:0]        MdOp,
  input  logic [DATA_W-1:0] DataIn1,
  input  logic [DATA_W-1:0] DataIn2,
  input  logic              HiWe,
  input  logic              LoWe,
  input  logic [DATA_W-1:0] HiLoData,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] Hi,
  output logic [DATA_W-1:0] Lo
);

  md_state_e               state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2*DATA_W-1:0]     acc_q, acc_d;
  logic [DATA_W-1:0]       opnd_q, opnd_d;
  logic                    is_div_q, is_div_d;
  logic                    neg_res_q, neg_res_d;
  logic                    neg_rem_q, neg_rem_d;
  logic [DATA_W-1:0]       hi_q, hi_d;
  logic [DATA_W-1:0]       lo_q, lo_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    sgn1, sgn2;
  logic [DATA_W-1:0]       mag1, mag2;
  logic [DATA_W:0]         mul_sum;
  logic [2*DATA_W-1:0]     mul_next;
  logic [DATA_W:0]         div_shift, div_diff;
  logic                    div_ok;
  logic [2*DATA_W-1:0]     div_next;
  logic [2*DATA_W-1:0]     prod_fix;
  logic [DATA_W-1:0]       quo_fix, rem_fix;

  assign sgn1 = op_is_signed(MdOp) & DataIn1[DATA_W-1];
  assign sgn2 = op_is_signed(MdOp) & DataIn2[DATA_W-1];

  md_sign_fix #(.W(DATA_W))   u_mag1 (.val(DataIn1), .neg(sgn1), .res(mag1));
  md_sign_fix #(.W(DATA_W))   u_mag2 (.val(DataIn2), .neg(sgn2), .res(mag2));
  md_sign_fix #(.W(2*DATA_W)) u_prod (.val(acc_q), .neg(neg_res_q), .res(prod_fix));
  md_sign_fix #(.W(DATA_W))   u_quo  (.val(acc_q[DATA_W-1:0]), .neg(neg_res_q), .res(quo_fix));
  md_sign_fix #(.W(DATA_W))   u_rem  (.val(acc_q[2*DATA_W-1:DATA_W]), .neg(neg_rem_q), .res(rem_fix));

  // Multiply: acc = {partial product, remaining multiplier bits}; add on LSB, shift right.
  assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[DATA_W-1:1]};

  // Divide: acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
  assign div_shift = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_ok    = ~div_diff[DATA_W];
  assign div_next  = {(div_ok ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0]),
                      acc_q[DATA_W-2:0], div_ok};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      MD_IDLE: begin
        if (Start) begin
          is_div_d  = op_is_div(MdOp);
          acc_d     = {{DATA_W{1'b0}}, (op_is_div(MdOp) ? mag1 : mag2)};
          opnd_d    = op_is_div(MdOp) ? mag2 : mag1;
          neg_res_d = sgn1 ^ sgn2;
          neg_rem_d = sgn1;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = MD_CALC;
        end else begin
          if (HiWe) hi_d = HiLoData;
          if (LoWe) lo_d = HiLoData;
        end
      end
      MD_CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = MD_FIX;
      end
      MD_FIX: begin
        if (is_div_q) begin
          // A zero divisor leaves the remainder equal to the raw dividend after sign fix.
          lo_d = (opnd_q == '0) ? '1 : quo_fix;
          hi_d = rem_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module  : tb_muldiv_unit
// Brief   : Self-checking bench: arithmetic reference model compared every
//           cycle plus directed vectors with hand-computed results.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, Start, HiWe, LoWe;
  logic [1:0]  MdOp;
  logic [31:0] DataIn1, DataIn2, HiLoData;
  logic        Busy, Done;
  logic [31:0] Hi, Lo;

  always #5 clk = ~clk;

  muldiv_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .Start(Start), .MdOp(MdOp),
    .DataIn1(DataIn1), .DataIn2(DataIn2),
    .HiWe(HiWe), .LoWe(LoWe), .HiLoData(HiLoData),
    .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  int done_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {HI, LO} straight from the arithmetic definition of each op.
  function automatic logic [63:0] expect_result(input logic [1:0] op,
                                                input logic [31:0] a,
                                                input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    int              q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'd0: return sa * sb;
      2'd1: return ua * ub;
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == 2'd3) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
    endcase
  endfunction

  // Latency model: an accepted Start retires exactly 33 edges later.
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        m_busy = 1'b0, m_done = 1'b0;
  int          m_remain = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_hi <= '0; m_lo <= '0; m_busy <= 1'b0; m_done <= 1'b0; m_remain <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_remain != 0) begin
        m_remain <= m_remain - 1;
        if (m_remain == 1) begin
          m_busy <= 1'b0; m_done <= 1'b1; m_hi <= p_hi; m_lo <= p_lo;
        end
      end else if (Start) begin
        {p_hi, p_lo} <= expect_result(MdOp, DataIn1, DataIn2);
        m_remain     <= 33;
        m_busy       <= 1'b1;
      end else begin
        if (HiWe) m_hi <= HiLoData;
        if (LoWe) m_lo <= HiLoData;
      end
    end
  end

  always @(negedge clk) begin
    if (Done === 1'b1) done_seen++;
    if (chk_en) begin
      check("cyc_busy", 32'(Busy), 32'(m_busy));
      check("cyc_done", 32'(Done), 32'(m_done));
      check("cyc_hi", Hi, m_hi);
      check("cyc_lo", Lo, m_lo);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; MdOp = op; DataIn1 = a; DataIn2 = b;
    tick(1);
    Start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (Done !== 1'b1 && n < 40) begin
      tick(1);
      n++;
    end
    check(name, 32'(Done), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int d0;
    rst = 1'b1; Start = 1'b0; MdOp = 2'd0; DataIn1 = '0; DataIn2 = '0;
    HiWe = 1'b0; LoWe = 1'b0; HiLoData = '0;
    tick(2);
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_hi", Hi, 32'h0);
    check("rst_lo", Lo, 32'h0);

    // MULTU max x max, with Busy duration measured
    start_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n = 0;
    while (Busy === 1'b1 && n < 40) begin
      n++;
      tick(1);
    end
    check("multu_busy_cycles", n, 32'd33);
    check("multu_done", 32'(Done), 32'd1);
    check("multu_hi", Hi, 32'hFFFF_FFFE);
    check("multu_lo", Lo, 32'h0000_0001);

    // MULT -3 x 7, then DIV -7 / 2 issued in the Done cycle
    start_op(2'd0, 32'hFFFF_FFFD, 32'd7);
    wait_done("mult_done");
    check("mult_hi", Hi, 32'hFFFF_FFFF);
    check("mult_lo", Lo, 32'hFFFF_FFEB);
    start_op(2'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_b2b_done");
    check("div_lo", Lo, 32'hFFFF_FFFD);
    check("div_hi", Hi, 32'hFFFF_FFFF);

    // divide by zero and signed overflow
    start_op(2'd3, 32'd100, 32'd0);
    wait_done("divu0_done");
    check("divu0_lo", Lo, 32'hFFFF_FFFF);
    check("divu0_hi", Hi, 32'h0000_0064);
    start_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("divovf_done");
    check("divovf_lo", Lo, 32'h8000_0000);
    check("divovf_hi", Hi, 32'h0);
    start_op(2'd2, 32'hFFFF_FF9C, 32'd0);
    wait_done("div0s_done");
    check("div0s_lo", Lo, 32'hFFFF_FFFF);
    check("div0s_hi", Hi, 32'hFFFF_FF9C);

    // operand changes and a second Start while busy are ignored
    start_op(2'd3, 32'd1000, 32'd7);
    tick(4);
    DataIn1 = 32'd5; DataIn2 = 32'd1; MdOp = 2'd0; Start = 1'b1;
    tick(1);
    Start = 1'b0;
    d0 = done_seen;
    wait_done("divu_ign_done");
    check("divu_ign_lo", Lo, 32'd142);
    check("divu_ign_hi", Hi, 32'd6);
    tick(40);
    check("divu_ign_done_count", 32'(done_seen - d0), 32'd1);

    // reset mid-operation aborts without a result
    start_op(2'd0, 32'h0001_2345, 32'h0000_0678);
    tick(9);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_done", 32'(Done), 32'd0);
    check("abort_hi", Hi, 32'h0);
    check("abort_lo", Lo, 32'h0);
    d0 = done_seen;
    tick(40);
    check("abort_no_done", 32'(done_seen - d0), 32'd0);

    // MTHI/MTLO writes
    HiWe = 1'b1; HiLoData = 32'h1234_5678;
    tick(1);
    HiWe = 1'b0;
    check("mthi_hi", Hi, 32'h1234_5678);
    check("mthi_lo", Lo, 32'h0);
    start_op(2'd1, 32'd3, 32'd5);
    LoWe = 1'b1; HiLoData = 32'hDEAD_BEEF;
    tick(1);
    LoWe = 1'b0;
    wait_done("busy_we_done");
    check("busy_we_lo", Lo, 32'd15);
    check("busy_we_hi", Hi, 32'd0);
    Start = 1'b1; MdOp = 2'd3; DataIn1 = 32'd20; DataIn2 = 32'd3;
    LoWe = 1'b1; HiLoData = 32'h0000_AAAA;
    tick(1);
    Start = 1'b0; LoWe = 1'b0;
    wait_done("start_we_done");
    check("start_we_lo", Lo, 32'd6);
    check("start_we_hi", Hi, 32'd2);

    tick(2);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
